clk_rst_seq: RTL and testbench

//  Parametrised clock-enable and reset sequencer for the UltraPlus system tops.

---
 rtl/clk_rst_seq.sv | 202 ++++++++++++++++++++
 tb/tb_clk_rst_seq.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_rst_seq.sv
// clk_rst_seq: clock-enable generator and ordered reset sequencer.
// A free-running divider produces phase-aligned single-cycle enables
// (ce[k] period 2^(k+1) clk cycles). After PLL lock has been stable for
// RESET_CYCLES cycles, the domain resets are released one at a time, lowest
// index first. Each release waits GAP_CYCLES idle cycles, then for the
// domain's ready, then for a slowest-enable pulse. Losing a released domain's
// ready re-sequences from that domain upward. Losing lock returns to HOLD.
// Handshake: dom_ready[i] is a level, not a pulse. Domain i leaves reset only
// on a cycle where it is 1, and must stay 1 for as long as i is released.
// A 0 on any released domain is taken as a request to reset that domain again.
// All outputs are registered, so no input reaches an output combinationally.
module clk_rst_seq #(
   parameter int NUM_EN       = 3,
   parameter int NUM_DOM      = 2,
   parameter int RESET_CYCLES = 1023,
   parameter int GAP_CYCLES   = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               pll_locked,
   input  logic [NUM_DOM-1:0] dom_ready,
   output logic [NUM_EN-1:0]  ce,
   output logic [NUM_DOM-1:0] dom_reset,
   output logic               all_ready
);

   localparam int STR_W = $clog2(RESET_CYCLES + 1);
   localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
   localparam int IDX_W = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1;

   localparam logic [STR_W-1:0] STR_LAST = STR_W'(RESET_CYCLES - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DOM - 1);

   typedef enum logic [1:0] {
      ST_HOLD    = 2'd0,
      ST_STRETCH = 2'd1,
      ST_SEQ     = 2'd2,
      ST_RUN     = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [NUM_EN-1:0]   div_q,   div_d;
   logic [STR_W-1:0]    str_q,   str_d;
   logic [GAP_W-1:0]    gap_q,   gap_d;
   logic [IDX_W-1:0]    idx_q,   idx_d;

   logic [NUM_EN-1:0]   ce_d;
   logic [NUM_DOM-1:0]  dom_reset_d;
   logic                all_ready_d;

   logic                lock_loss;
   logic                gap_done;
   logic                cur_ready;
   logic                release_now;
   logic                lost_any;
   logic [NUM_DOM-1:0]  lost;
   logic [IDX_W-1:0]    lost_idx;

   // Event decode: lock loss, lowest released domain that dropped ready,
   // and whether the current domain may be released this cycle. A release
   // is decided when the divider is all ones, so the domain's reset falls
   // on the same edge as the slowest enable pulse.
   always_comb begin
      lock_loss = (state_q != ST_HOLD) && !pll_locked;
      lost      = ~dom_reset & ~dom_ready;
      lost_any  = 1'b0;
      lost_idx  = '0;
      for (int i = NUM_DOM - 1; i >= 0; i--) begin
         if (lost[i]) begin
            lost_any = 1'b1;
            lost_idx = IDX_W'(i);
         end
      end
      cur_ready = 1'b0;
      for (int i = 0; i < NUM_DOM; i++) begin
         if (idx_q == IDX_W'(i)) begin
            cur_ready = dom_ready[i];
         end
      end
      gap_done    = (gap_q == GAP_LAST);
      release_now = (state_q == ST_SEQ) && gap_done && cur_ready && (&div_q);
   end

   // State register with divider, stretch, gap and index counters.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_HOLD;
         div_q   <= '0;
         str_q   <= '0;
         gap_q   <= '0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         str_q   <= str_d;
         gap_q   <= gap_d;
         idx_q   <= idx_d;
      end
   end

   // Next-state and counter update; lock loss overrides ready loss, which
   // overrides a release decided in the same cycle.
   always_comb begin
      state_d = state_q;
      str_d   = str_q;
      gap_d   = gap_q;
      idx_d   = idx_q;
      div_d   = (state_q == ST_HOLD || lock_loss) ? '0 : div_q + NUM_EN'(1);
      case (state_q)
         ST_HOLD: begin
            if (pll_locked) begin
               state_d = ST_STRETCH;
               str_d   = '0;
            end
         end
         ST_STRETCH: begin
            if (str_q == STR_LAST) begin
               state_d = ST_SEQ;
               idx_d   = '0;
               gap_d   = '0;
            end else begin
               str_d = str_q + STR_W'(1);
            end
         end
         ST_SEQ: begin
            if (!gap_done) begin
               gap_d = gap_q + GAP_W'(1);
            end else if (release_now) begin
               if (idx_q == IDX_LAST) begin
                  state_d = ST_RUN;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
                  gap_d = '0;
               end
            end
         end
         ST_RUN: begin
            state_d = ST_RUN;
         end
         default: begin
            state_d = ST_HOLD;
         end
      endcase
      if (lost_any && (state_q == ST_SEQ || state_q == ST_RUN)) begin
         state_d = ST_SEQ;
         idx_d   = lost_idx;
         gap_d   = '0;
      end
      if (lock_loss) begin
         state_d = ST_HOLD;
         str_d   = '0;
         gap_d   = '0;
         idx_d   = '0;
      end
   end

   // Next values of the registered outputs.
   always_comb begin
      logic run_and;
      run_and = 1'b1;
      ce_d    = '0;
      for (int k = 0; k < NUM_EN; k++) begin
         run_and = run_and & div_q[k];
         ce_d[k] = run_and;
      end
      dom_reset_d = dom_reset;
      if (release_now) begin
         for (int i = 0; i < NUM_DOM; i++) begin
            if (idx_q == IDX_W'(i)) begin
               dom_reset_d[i] = 1'b0;
            end
         end
      end
      if (lost_any) begin
         for (int i = 0; i < NUM_DOM; i++) begin
            if (IDX_W'(i) >= lost_idx) begin
               dom_reset_d[i] = 1'b1;
            end
         end
      end
      if (state_q == ST_HOLD || lock_loss) begin
         dom_reset_d = '1;
         ce_d        = '0;
      end
      all_ready_d = (state_d == ST_RUN);
   end

   // Output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ce        <= '0;
         dom_reset <= '1;
         all_ready <= 1'b0;
      end else begin
         ce        <= ce_d;
         dom_reset <= dom_reset_d;
         all_ready <= all_ready_d;
      end
   end

endmodule

// File: tb/tb_clk_rst_seq.sv
// tb_clk_rst_seq: drives a default clk_rst_seq (inst A) and a minimal one
// (inst B: NUM_EN=1, NUM_DOM=1, RESET_CYCLES=1, GAP_CYCLES=0) from one clock
// and reset, and compares both against a cycle-level reference model that
// tracks time since lock and the number of released domains.
module tb_clk_rst_seq;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       lock_a = 1'b0;
   logic       lock_b = 1'b0;
   logic [1:0] ready_a = 2'b11;
   logic [0:0] ready_b = 1'b1;
   logic [2:0] ce_a;
   logic [1:0] rst_a;
   logic       ar_a;
   logic [0:0] ce_b;
   logic [0:0] rst_b;
   logic       ar_b;

   int cyc = 0;
   int vectors = 0;
   int miscompares = 0;

   // Model parameters per instance.
   int p_en  [2] = '{3, 1};
   int p_dom [2] = '{2, 1};
   int p_rc  [2] = '{1023, 1};
   int p_gap [2] = '{16, 0};

   // Model state: in HOLD, cycles since leaving HOLD, released count,
   // cycle (in the same time base) at which the current wait began.
   int m_hold [2];
   int m_n    [2];
   int m_rel  [2];
   int m_wait [2];

   clk_rst_seq u_a (
      .clk        (clk),
      .reset      (reset),
      .pll_locked (lock_a),
      .dom_ready  (ready_a),
      .ce         (ce_a),
      .dom_reset  (rst_a),
      .all_ready  (ar_a)
   );

   clk_rst_seq #(
      .NUM_EN       (1),
      .NUM_DOM      (1),
      .RESET_CYCLES (1),
      .GAP_CYCLES   (0)
   ) u_b (
      .clk        (clk),
      .reset      (reset),
      .pll_locked (lock_b),
      .dom_ready  (ready_b),
      .ce         (ce_b),
      .dom_reset  (rst_b),
      .all_ready  (ar_b)
   );

   // Clock and cycle counter.
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic void model_reset();
      for (int i = 0; i < 2; i++) begin
         m_hold[i] = 1;
         m_n[i]    = 0;
         m_rel[i]  = 0;
         m_wait[i] = 0;
      end
   endfunction

   function automatic void model_step(input int i, input logic lock, input logic [1:0] rdy);
      int j_lost;
      int period;
      period = 1 << p_en[i];
      if (m_hold[i] != 0) begin
         if (lock) begin
            m_hold[i] = 0;
            m_n[i]    = 0;
            m_rel[i]  = 0;
            m_wait[i] = p_rc[i];
         end
      end else if (!lock) begin
         m_hold[i] = 1;
         m_rel[i]  = 0;
      end else begin
         j_lost = -1;
         for (int j = m_rel[i] - 1; j >= 0; j--) begin
            if (!rdy[j]) j_lost = j;
         end
         if (j_lost >= 0) begin
            m_rel[i]  = j_lost;
            m_wait[i] = m_n[i] + 1;
         end else if (m_rel[i] < p_dom[i] && m_n[i] >= m_wait[i] + p_gap[i]) begin
            if (rdy[m_rel[i]] && ((m_n[i] + 1) % period == 0)) begin
               m_rel[i]  = m_rel[i] + 1;
               m_wait[i] = m_n[i] + 1;
            end
         end
         m_n[i] = m_n[i] + 1;
      end
   endfunction

   // Reference model advances on every clock edge from the inputs of the
   // cycle just ended; async reset returns it to HOLD at once.
   always @(posedge clk or posedge reset) begin
      if (reset) model_reset();
      else begin
         model_step(0, lock_a, ready_a);
         model_step(1, lock_b, {1'b1, ready_b});
      end
   end

   // Expected {ce[2:0], dom_reset[1:0], all_ready}; unused bits are 0 for B.
   function automatic logic [5:0] exp_word(input int i);
      logic [2:0] e_ce;
      logic [1:0] e_rst;
      logic       e_ar;
      e_ce  = '0;
      e_rst = '1;
      e_ar  = 1'b0;
      if (m_hold[i] == 0) begin
         for (int k = 0; k < p_en[i]; k++) e_ce[k] = (m_n[i] > 0) && (m_n[i] % (2 << k) == 0);
         for (int d = 0; d < p_dom[i]; d++) e_rst[d] = (d >= m_rel[i]);
         e_ar = (m_rel[i] == p_dom[i]);
      end
      if (i == 1) begin
         e_ce[2:1] = 2'b00;
         e_rst[1]  = 1'b0;
      end
      return {e_ce, e_rst, e_ar};
   endfunction

   function automatic logic [5:0] dut_word(input int i);
      if (i == 0) return {ce_a, rst_a, ar_a};
      return {2'b00, ce_b, 1'b0, rst_b, ar_b};
   endfunction

   // Driver: pulse the shared reset for one cycle.
   task automatic pulse_reset();
      @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      #2 reset = 1'b1;
      #1;
      vectors++;
      if (dut_word(0) !== 6'b000110 || dut_word(1) !== 6'b000010) begin
         miscompares++;
         $display("FAIL reset_value got=%b/%b exp=000110/000010", dut_word(0), dut_word(1));
      end
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      for (int c = 0; c < 5000; c++) begin
         @(negedge clk);
         vectors++;
         if (dut_word(0) !== 6'b000110 || dut_word(1) !== 6'b000010) begin
            miscompares++;
            $display("FAIL hold_unlocked cyc=%0d got=%b/%b exp=000110/000010", cyc, dut_word(0), dut_word(1));
         end
      end
   endtask

   task automatic test_sequence();
      int lock_cyc, r0, r1, ar_rise, exp_n0, exp_n1;
      logic [1:0] prev_rst;
      logic prev_ar;
      r0 = -1; r1 = -1; ar_rise = -1;
      prev_rst = rst_a;
      prev_ar  = ar_a;
      @(posedge clk);
      #1;
      lock_a   = 1'b1;
      ready_a  = 2'b11;
      lock_cyc = cyc;
      for (int c = 0; c < 1200; c++) begin
         @(negedge clk);
         vectors++;
         if (dut_word(0) !== exp_word(0) || dut_word(1) !== exp_word(1)) begin
            miscompares++;
            $display("FAIL sequence cyc=%0d got=%b/%b exp=%b/%b", cyc, dut_word(0), dut_word(1), exp_word(0), exp_word(1));
         end
         if (prev_rst[0] && !rst_a[0]) r0 = cyc;
         if (prev_rst[1] && !rst_a[1]) r1 = cyc;
         if (!prev_ar && ar_a) ar_rise = cyc;
         prev_rst = rst_a;
         prev_ar  = ar_a;
      end
      // First aligned slot after stretch plus gap, then again after another gap.
      exp_n0 = ((1023 + 16 + 1 + 7) / 8) * 8;
      exp_n1 = ((exp_n0 + 16 + 1 + 7) / 8) * 8;
      vectors++;
      if (r0 !== lock_cyc + 1 + exp_n0) begin
         miscompares++;
         $display("FAIL release0_cycle got=%0d exp=%0d", r0, lock_cyc + 1 + exp_n0);
      end
      vectors++;
      if (r1 !== lock_cyc + 1 + exp_n1 || ar_rise !== r1) begin
         miscompares++;
         $display("FAIL release1_cycle got=%0d/%0d exp=%0d", r1, ar_rise, lock_cyc + 1 + exp_n1);
      end
   endtask

   task automatic test_ready_wait();
      int c;
      pulse_reset();
      ready_a = 2'b01;
      c = 0;
      while (rst_a[0] !== 1'b0 && c < 1300) begin
         @(negedge clk);
         c++;
         vectors++;
         if (dut_word(0) !== exp_word(0) || dut_word(1) !== exp_word(1)) begin
            miscompares++;
            $display("FAIL ready_wait_a cyc=%0d got=%b/%b exp=%b/%b", cyc, dut_word(0), dut_word(1), exp_word(0), exp_word(1));
         end
      end
      for (int k = 0; k < 600; k++) begin
         @(posedge clk);
         #1;
         if (k == 500) ready_a = 2'b11;
         @(negedge clk);
         vectors++;
         if (dut_word(0) !== exp_word(0) || dut_word(1) !== exp_word(1)) begin
            miscompares++;
            $display("FAIL ready_wait_b cyc=%0d got=%b/%b exp=%b/%b", cyc, dut_word(0), dut_word(1), exp_word(0), exp_word(1));
         end
      end
      vectors++;
      if (ar_a !== 1'b1 || rst_a !== 2'b00) begin
         miscompares++;
         $display("FAIL ready_wait_end got=%b%b exp=001", rst_a, ar_a);
      end
   endtask

   task automatic test_ready_loss();
      @(posedge clk);
      #1 ready_a = 2'b10;
      @(posedge clk);
      #1 ready_a = 2'b11;
      @(negedge clk);
      vectors++;
      if (rst_a !== 2'b11 || ar_a !== 1'b0) begin
         miscompares++;
         $display("FAIL ready_loss_next got=%b%b exp=110", rst_a, ar_a);
      end
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         vectors++;
         if (dut_word(0) !== exp_word(0) || dut_word(1) !== exp_word(1)) begin
            miscompares++;
            $display("FAIL ready_loss cyc=%0d got=%b/%b exp=%b/%b", cyc, dut_word(0), dut_word(1), exp_word(0), exp_word(1));
         end
      end
      vectors++;
      if (ar_a !== 1'b1) begin
         miscompares++;
         $display("FAIL ready_loss_rerun got=%b exp=1", ar_a);
      end
   endtask

   task automatic test_lock_loss();
      int relock, ar_rise;
      logic prev_ar;
      @(posedge clk);
      #1;
      lock_a  = 1'b0;
      ready_a = 2'b01;
      @(posedge clk);
      #1;
      lock_a  = 1'b1;
      ready_a = 2'b11;
      relock  = cyc;
      @(negedge clk);
      vectors++;
      if (ce_a !== 3'b000 || rst_a !== 2'b11 || ar_a !== 1'b0) begin
         miscompares++;
         $display("FAIL lock_loss_next got=%b/%b/%b exp=000/11/0", ce_a, rst_a, ar_a);
      end
      ar_rise = -1;
      prev_ar = ar_a;
      for (int c = 0; c < 1200; c++) begin
         @(negedge clk);
         vectors++;
         if (dut_word(0) !== exp_word(0) || dut_word(1) !== exp_word(1)) begin
            miscompares++;
            $display("FAIL lock_loss cyc=%0d got=%b/%b exp=%b/%b", cyc, dut_word(0), dut_word(1), exp_word(0), exp_word(1));
         end
         if (!prev_ar && ar_a) ar_rise = cyc;
         prev_ar = ar_a;
      end
      vectors++;
      if (ar_rise !== relock + 1 + 1064) begin
         miscompares++;
         $display("FAIL relock_run_cycle got=%0d exp=%0d", ar_rise, relock + 1 + 1064);
      end
   endtask

   task automatic test_small();
      int lock_cyc, fall;
      logic prev;
      fall = -1;
      prev = rst_b[0];
      @(posedge clk);
      #1;
      lock_b   = 1'b1;
      ready_b  = 1'b1;
      lock_cyc = cyc;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         vectors++;
         if (dut_word(0) !== exp_word(0) || dut_word(1) !== exp_word(1)) begin
            miscompares++;
            $display("FAIL small cyc=%0d got=%b/%b exp=%b/%b", cyc, dut_word(0), dut_word(1), exp_word(0), exp_word(1));
         end
         if (prev && !rst_b[0]) fall = cyc;
         prev = rst_b[0];
      end
      vectors++;
      if (fall !== lock_cyc + 3) begin
         miscompares++;
         $display("FAIL small_release_cycle got=%0d exp=%0d", fall, lock_cyc + 3);
      end
      // Park B in SEQ waiting for ready, then hit async reset mid-cycle.
      ready_b = 1'b0;
      pulse_reset();
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         vectors++;
         if (dut_word(0) !== exp_word(0) || dut_word(1) !== exp_word(1)) begin
            miscompares++;
            $display("FAIL small_seq cyc=%0d got=%b/%b exp=%b/%b", cyc, dut_word(0), dut_word(1), exp_word(0), exp_word(1));
         end
      end
      ready_b = 1'b1;
      #2 reset = 1'b1;
      #1;
      vectors++;
      if (dut_word(0) !== 6'b000110 || dut_word(1) !== 6'b000010) begin
         miscompares++;
         $display("FAIL async_reset_mid_seq got=%b/%b exp=000110/000010", dut_word(0), dut_word(1));
      end
      @(posedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic test_random();
      for (int c = 0; c < 20000; c++) begin
         @(posedge clk);
         #1;
         if (lock_a) lock_a = ($urandom_range(0, 3999) != 0);
         else        lock_a = ($urandom_range(0, 2) == 0);
         for (int b = 0; b < 2; b++) begin
            if (ready_a[b]) ready_a[b] = ($urandom_range(0, 299) != 0);
            else            ready_a[b] = ($urandom_range(0, 9) == 0);
         end
         if (lock_b) lock_b = ($urandom_range(0, 49) != 0);
         else        lock_b = ($urandom_range(0, 2) == 0);
         if (ready_b[0]) ready_b[0] = ($urandom_range(0, 19) != 0);
         else            ready_b[0] = ($urandom_range(0, 3) == 0);
         @(negedge clk);
         vectors++;
         if (dut_word(0) !== exp_word(0) || dut_word(1) !== exp_word(1)) begin
            miscompares++;
            $display("FAIL random cyc=%0d got=%b/%b exp=%b/%b", cyc, dut_word(0), dut_word(1), exp_word(0), exp_word(1));
         end
      end
   endtask

   initial begin
      test_reset();
      test_sequence();
      test_ready_wait();
      test_ready_loss();
      test_lock_loss();
      test_small();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
